spinner_bank: RTL

- Multi-channel rotary-control emulator for arcade cores.
- Converts digital rotate-CW/CCW inputs into wrapping angle registers that the game reads through its input ports.
- Generalises the single-channel spinner:
  - N channels.
  - Parametrised angle width.
  - Per-channel mode: Buttons (notch step with autorepeat) or Spinner (continuous with acceleration).
- Sits between the emu-level control mapping and the core's input_N buses; updates are paced by the video VSync strobe.

---
 rtl/spinner_bank_pkg.sv | 25 ++
 rtl/spinner_chan.sv | 154 +++++++++++++++
 rtl/spinner_bank.sv | 71 +++++++
 3 files changed

// File: rtl/spinner_bank_pkg.sv
// Shared types and helpers for the spinner_bank rotary-control emulator.
// Enumerations for channel state and stroke direction, plus saturating speed arithmetic.
package spinner_bank_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDelay,
    StRun
  } state_e;

  typedef enum logic [1:0] {
    DirNone,
    DirCw,
    DirCcw
  } dir_e;

  function automatic int unsigned sat_add(input int unsigned speed,
                                          input int unsigned accel,
                                          input int unsigned max_v);
    int unsigned sum;
    sum = speed + accel;
    return (sum > max_v) ? max_v : sum;
  endfunction

endpackage

// File: rtl/spinner_chan.sv
// One spinner channel: mode FSM, repeat/speed counters and the wrapping angle register.
// Optional relative-motion input is compiled in with SPINNER_BANK_DELTA_EN.
module spinner_chan
  import spinner_bank_pkg::*;
#(
  parameter int unsigned ANGLE_W      = 8,
  parameter int unsigned RESET_ANGLE  = 0,
  parameter int unsigned STEP_BTN     = 4,
  parameter int unsigned REPEAT_DELAY = 8,
  parameter int unsigned REPEAT_RATE  = 2,
  parameter int unsigned STEP_MIN     = 2,
  parameter int unsigned STEP_MAX     = 16,
  parameter int unsigned ACCEL        = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_edge,
  input  logic               i_plus,
  input  logic               i_minus,
  input  logic               i_use_spinner,
`ifdef SPINNER_BANK_DELTA_EN
  input  logic [7:0]         i_delta,
  input  logic               i_delta_valid,
`endif
  output logic [ANGLE_W-1:0] o_angle,
  output logic               o_active,
  output logic               o_step_pulse
);

  localparam int unsigned CntMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned CNT_W  = $clog2(CntMax + 2);
  localparam int unsigned SpdTop = (STEP_MAX > STEP_MIN) ? STEP_MAX : STEP_MIN;
  localparam int unsigned SPD_W  = $clog2(SpdTop + 2);

  localparam logic [SPD_W-1:0] SpdMin   = SPD_W'(STEP_MIN);
  localparam logic [SPD_W-1:0] SpdFirst = SPD_W'(sat_add(STEP_MIN, ACCEL, STEP_MAX));

  state_e             r_state_q, w_state_d;
  dir_e               r_dir_q, w_dir_d, w_dir_req;
  logic [CNT_W-1:0]   r_cnt_q, w_cnt_d, w_cnt_inc;
  logic [SPD_W-1:0]   r_speed_q, w_speed_d;
  logic               r_mode_q, w_mode_d;
  logic [ANGLE_W-1:0] r_angle_q, w_angle_d, w_step_mag;
  logic               r_pulse_q;
  logic               w_step_en, w_fresh;

`ifdef SPINNER_BANK_DELTA_EN
  logic [31:0] w_delta_sx;
  assign w_delta_sx = {{24{i_delta[7]}}, i_delta};
`endif

  always_comb begin
    w_dir_req = DirNone;
    if (i_plus && !i_minus) begin
      w_dir_req = DirCw;
    end else if (i_minus && !i_plus) begin
      w_dir_req = DirCcw;
    end

    w_state_d  = r_state_q;
    w_dir_d    = r_dir_q;
    w_cnt_d    = r_cnt_q;
    w_speed_d  = r_speed_q;
    w_mode_d   = r_mode_q;
    w_step_en  = 1'b0;
    w_step_mag = '0;
    w_fresh    = 1'b0;
    w_cnt_inc  = r_cnt_q + CNT_W'(1);

    if (i_edge) begin
      if (r_state_q == StIdle) begin
        w_fresh = (w_dir_req != DirNone);
      end else if ((i_use_spinner != r_mode_q) || (w_dir_req == DirNone)) begin
        // Release or mode flip abandons the hold without a step.
        w_state_d = StIdle;
        w_cnt_d   = '0;
        w_speed_d = SpdMin;
      end else if (w_dir_req != r_dir_q) begin
        w_fresh = 1'b1;
      end else if (r_state_q == StDelay) begin
        if (r_cnt_q == CNT_W'(REPEAT_DELAY)) begin
          w_step_en  = 1'b1;
          w_step_mag = ANGLE_W'(STEP_BTN);
          w_state_d  = StRun;
          w_cnt_d    = '0;
        end else begin
          w_cnt_d = w_cnt_inc;
        end
      end else if (r_mode_q) begin
        w_step_en  = 1'b1;
        w_step_mag = ANGLE_W'(r_speed_q);
        w_speed_d  = SPD_W'(sat_add(32'(r_speed_q), ACCEL, STEP_MAX));
      end else if (w_cnt_inc == CNT_W'(REPEAT_RATE)) begin
        w_step_en  = 1'b1;
        w_step_mag = ANGLE_W'(STEP_BTN);
        w_cnt_d    = '0;
      end else begin
        w_cnt_d = w_cnt_inc;
      end

      if (w_fresh) begin
        w_step_en = 1'b1;
        w_dir_d   = w_dir_req;
        w_mode_d  = i_use_spinner;
        w_cnt_d   = '0;
        if (i_use_spinner) begin
          w_step_mag = ANGLE_W'(STEP_MIN);
          w_state_d  = StRun;
          w_speed_d  = SpdFirst;
        end else begin
          w_step_mag = ANGLE_W'(STEP_BTN);
          w_state_d  = StDelay;
          w_speed_d  = SpdMin;
        end
      end
    end

    // Any step taken this edge is in the requested direction.
    w_angle_d = r_angle_q;
    if (w_step_en) begin
      w_angle_d = (w_dir_req == DirCcw) ? (r_angle_q - w_step_mag) : (r_angle_q + w_step_mag);
    end
`ifdef SPINNER_BANK_DELTA_EN
    if (i_delta_valid) begin
      w_angle_d = w_angle_d + ANGLE_W'(w_delta_sx);
    end
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state_q <= StIdle;
      r_dir_q   <= DirNone;
      r_cnt_q   <= '0;
      r_speed_q <= SpdMin;
      r_mode_q  <= 1'b0;
      r_angle_q <= ANGLE_W'(RESET_ANGLE);
      r_pulse_q <= 1'b0;
    end else begin
      r_state_q <= w_state_d;
      r_dir_q   <= w_dir_d;
      r_cnt_q   <= w_cnt_d;
      r_speed_q <= w_speed_d;
      r_mode_q  <= w_mode_d;
      r_angle_q <= w_angle_d;
      r_pulse_q <= w_step_en;
    end
  end

  assign o_angle      = r_angle_q;
  assign o_active     = (r_state_q != StIdle);
  assign o_step_pulse = r_pulse_q;

endmodule

// File: rtl/spinner_bank.sv
// Multi-channel rotary-control emulator: VSync edge detect plus per-channel spinner_chan array.
// Define SPINNER_BANK_DELTA_EN to add the delta/delta_valid relative-motion inputs.
module spinner_bank
  import spinner_bank_pkg::*;
#(
  parameter int unsigned CHANNELS     = 2,
  parameter int unsigned ANGLE_W      = 8,
  parameter int unsigned RESET_ANGLE  = 0,
  parameter int unsigned STEP_BTN     = 4,
  parameter int unsigned REPEAT_DELAY = 8,
  parameter int unsigned REPEAT_RATE  = 2,
  parameter int unsigned STEP_MIN     = 2,
  parameter int unsigned STEP_MAX     = 16,
  parameter int unsigned ACCEL        = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        strobe,
  input  logic [CHANNELS-1:0]         plus,
  input  logic [CHANNELS-1:0]         minus,
  input  logic [CHANNELS-1:0]         use_spinner,
`ifdef SPINNER_BANK_DELTA_EN
  input  logic [CHANNELS*8-1:0]       delta,
  input  logic [CHANNELS-1:0]         delta_valid,
`endif
  output logic [CHANNELS*ANGLE_W-1:0] angle,
  output logic [CHANNELS-1:0]         active,
  output logic [CHANNELS-1:0]         step_pulse
);

  logic r_strobe_q;
  logic w_edge;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_strobe_q <= 1'b0;
    end else begin
      r_strobe_q <= strobe;
    end
  end

  assign w_edge = strobe & ~r_strobe_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    spinner_chan #(
      .ANGLE_W      (ANGLE_W),
      .RESET_ANGLE  (RESET_ANGLE),
      .STEP_BTN     (STEP_BTN),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE),
      .STEP_MIN     (STEP_MIN),
      .STEP_MAX     (STEP_MAX),
      .ACCEL        (ACCEL)
    ) u_chan (
      .i_clk         (clk),
      .i_rst_n       (reset_n),
      .i_edge        (w_edge),
      .i_plus        (plus[g]),
      .i_minus       (minus[g]),
      .i_use_spinner (use_spinner[g]),
`ifdef SPINNER_BANK_DELTA_EN
      .i_delta       (delta[g*8 +: 8]),
      .i_delta_valid (delta_valid[g]),
`endif
      .o_angle       (angle[g*ANGLE_W +: ANGLE_W]),
      .o_active      (active[g]),
      .o_step_pulse  (step_pulse[g])
    );
  end

endmodule
